// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional feature macro: MULDIV_EARLY_OUT_EN (see hilo_muldiv_ctrl).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    WB
  } state_e;

  localparam logic [2:0]  HILO_FLAG_BOTH = 3'b111;
  localparam int unsigned DIV_ITER       = 32;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_ITER);

  // Sign- or zero-extend both operands to 64 bits; the truncated product is then
  // correct for both signed and unsigned multiplies.
  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] abs32(input logic sgn, input logic [31:0] v);
    return (sgn & v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring unsigned divider datapath: one quotient bit per step, DIV_ITER steps.
// load_i with bypass_i presets quotient 0 / remainder = dividend (early-out path).
module div_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bypass_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o
);

  logic [31:0]          quo_q, quo_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          dvs_q, dvs_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]          rem_sh;
  logic [32:0]          diff;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    // The remainder is always below the divisor, so the shifted value fits 33 bits
    // and bit 32 of the difference is a clean borrow flag.
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (load_i) begin
      quo_d = bypass_i ? 32'd0 : dividend_i;
      rem_d = bypass_i ? dividend_i : 32'd0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + DIV_CNT_W'(1);
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == DIV_CNT_W'(DIV_ITER - 1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning the single 64-bit HI/LO register-file write.
// Define MULDIV_EARLY_OUT_EN to let divides with |a| < |b| skip the iteration loop.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wd,
  output logic [2:0]  hilo_flag,
  output logic        div_zero
);

  // Counter value on the last MUL-state cycle; MUL is skipped entirely when MUL_LAT == 1.
  localparam int unsigned MulLast = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [7:0]  mul_cnt_q, mul_cnt_d;
  logic [63:0] hilo_wd_q, hilo_wd_d;

  op_e         op_in;
  logic        accept;
  logic        in_signed_div;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        early;
  logic        div_load;
  logic        div_step;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_last;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign op_in         = op_e'(op);
  assign accept        = start & ~flush & (state_q == IDLE);
  assign in_signed_div = (op_in == OP_DIV);
  assign b_zero        = (src_b == 32'd0);
  assign abs_a         = abs32(in_signed_div, src_a);
  assign abs_b         = abs32(in_signed_div, src_b);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = ~b_zero & (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  assign div_load = accept & op[1] & ~b_zero;
  assign div_step = (state_q == DIV);

  div_iter_core u_div_iter_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (div_load),
    .bypass_i   (early),
    .step_i     (div_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .last_o     (div_last)
  );

  assign q_fix = q_neg_q ? (~quotient + 32'd1) : quotient;
  assign r_fix = r_neg_q ? (~remainder + 32'd1) : remainder;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!op[1]) begin
            state_d = (MUL_LAT == 1) ? WB : MUL;
          end else if (b_zero) begin
            state_d = WB;
          end else if (early) begin
            state_d = FIX;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL:     if (mul_cnt_q == 8'(MulLast)) state_d = WB;
      DIV:     if (div_last) state_d = FIX;
      FIX:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && (state_q != IDLE)) state_d = IDLE;
    busy_d = (state_d != IDLE);
  end

  // Operand latch, multiply pipeline and divide sign fix-up
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    mul_cnt_d = mul_cnt_q;
    hilo_wd_d = hilo_wd_q;
    if (accept) begin
      op_d      = op_in;
      a_d       = src_a;
      b_d       = src_b;
      q_neg_d   = in_signed_div & (src_a[31] ^ src_b[31]);
      r_neg_d   = in_signed_div & src_a[31];
      dz_d      = op[1] & b_zero;
      mul_cnt_d = 8'd0;
      if ((MUL_LAT == 1) && !op[1]) hilo_wd_d = mul64(op_in == OP_MULT, src_a, src_b);
    end else if (!flush) begin
      if (state_q == MUL) begin
        mul_cnt_d = mul_cnt_q + 8'd1;
        if (mul_cnt_q == 8'(MulLast)) hilo_wd_d = mul64(op_q == OP_MULT, a_q, b_q);
      end else if (state_q == FIX) begin
        hilo_wd_d = {r_fix, q_fix};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      mul_cnt_q <= '0;
      hilo_wd_q <= '0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dz_q      <= dz_d;
      mul_cnt_q <= mul_cnt_d;
      hilo_wd_q <= hilo_wd_d;
    end
  end

  // Outputs: WB releases the pipeline while the write is on the port
  always_comb begin
    busy      = busy_q;
    stall     = (busy_q & (state_q != WB)) | accept;
    hilo_we   = (state_q == WB) & ~dz_q;
    div_zero  = (state_q == WB) & dz_q;
    hilo_flag = hilo_we ? HILO_FLAG_BOTH : 3'b000;
    hilo_wd   = hilo_wd_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed ops push expected writes, a monitor
// pops them on each hilo_we/div_zero and checks data, flag and cycle of arrival.
module tb_hilo_muldiv_ctrl;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_wd;
  logic [2:0]  hilo_flag;
  logic        div_zero;

  hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hilo_wd  (hilo_wd),
    .hilo_flag(hilo_flag),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    bit          dz;
    logic [63:0] wd;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: every write or divide-by-zero pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (hilo_we || div_zero)) begin
      if (sb.size() == 0) begin
        chk("unexpected_hilo_we", {62'd0, hilo_we, div_zero}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_kind"}, {hilo_we, div_zero}, mon_e.dz ? 2'b01 : 2'b10);
        chk({mon_e.name, "_cycle"}, cyc, mon_e.due);
        chk({mon_e.name, "_flag"}, hilo_flag, mon_e.dz ? 3'b000 : 3'b111);
        if (!mon_e.dz) chk({mon_e.name, "_wd"}, hilo_wd, mon_e.wd);
        chk({mon_e.name, "_stall_wb"}, stall, 1'b0);
      end
    end
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit dz, input logic [63:0] wd,
                        input int lat, input bit wb_flush);
    int acc0;
    int rel;
    @(negedge clk);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    acc0  = cyc;
    sb.push_back('{nm, dz, wd, acc0 + lat});
    #1 chk({nm, "_stall_c0"}, stall, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    rel = 1;
    chk({nm, "_stall_c1"}, stall, (lat > 1) ? 1'b1 : 1'b0);
    while (sb.size() != 0 && rel < 100) begin
      flush = wb_flush && (rel == lat);
      @(posedge clk);
      #1 rel++;
    end
    flush = 1'b0;
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, sb.size(), 64'd0);
      sb.delete();
    end
    chk({nm, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_hilo_we", hilo_we, 1'b0);
    chk("rst_hilo_wd", hilo_wd, 64'd0);
    chk("rst_hilo_flag", hilo_flag, 3'b000);
    chk("rst_div_zero", div_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    run_op("mult_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 64'hFFFF_FFFF_FFFF_FFFA, 2, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 2, 0);
    run_op("mult_wbflush", 2'b00, 32'd7, 32'hFFFF_FFFB, 0, 64'hFFFF_FFFF_FFFF_FFDD, 2, 1);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 64'h0000_0001_FFFF_FFFD, 34, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h0000_0000_8000_0000, 34, 0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0, {32'd2, 32'd14}, 34, 0);
    run_op("divu_5_9", 2'b11, 32'd5, 32'd9, 0, {32'd5, 32'd0}, EarlyLat, 0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1, 64'd0, 1, 0);

    // Flush a DIVU during cycle 10: back to IDLE at cycle 11, no write ever appears.
    @(negedge clk);
    op    = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    chk("flush_busy_c10", busy, 1'b1);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_c11", busy, 1'b0);
    chk("flush_stall_c11", stall, 1'b0);
    repeat (40) @(posedge clk);
    run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 0, 64'd15, 2, 0);

    // start together with flush in IDLE is ignored.
    @(negedge clk);
    op    = 2'b01;
    src_a = 32'd2;
    src_b = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    #1 chk("startflush_stall", stall, 1'b0);
    @(posedge clk);
    #1 chk("startflush_busy", busy, 1'b0);
    start = 1'b0;
    flush = 1'b0;

    // Reset in the middle of a divide clears everything at once.
    @(negedge clk);
    op    = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_hilo_we", hilo_we, 1'b0);
    chk("midrst_hilo_wd", hilo_wd, 64'd0);
    chk("midrst_hilo_flag", hilo_flag, 3'b000);
    chk("midrst_div_zero", div_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    run_op("mult_after_rst", 2'b00, 32'd6, 32'd7, 0, 64'd42, 2, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
